// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
// Holds the FSM state encoding, the nibble width and helpers that derive
// the nibble count and index-counter width from the operand width.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int num_nibbles(input int width);
    return width / NIB_W;
  endfunction

  // A single-nibble datapath still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/done handshake bundle between the operand source and the
// nibble-serial adder.
//   start, sub, A, B : request side (driven by master)
//   busy, done       : handshake status (driven by slave)
//   R, cout,
//   overflow, zero   : latched result and flags (driven by slave)
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, A, B,
    input  busy, done, R, cout, overflow, zero
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, R, cout, overflow, zero
  );

endinterface

// File: rtl/carry_look_ahead_adder_cin_cout_4.sv
// 4-bit carry-look-ahead adder with carry in and carry out.
//   a, b : nibble operands
//   cin  : carry in
//   sum  : nibble sum
//   cout : carry out of bit 3
module carry_look_ahead_adder_cin_cout_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from cin so no carry ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit CLA.
// One nibble is added per clock, LSB nibble first, with the carry held in a
// register between cycles. Subtraction inverts B and seeds the carry with 1.
//   clk   : clock, rising edge
//   reset : synchronous, active high; aborts any operation in flight
//   bus   : start/sub/A/B request, busy/done status, R and flags
//
// state | meaning
// IDLE  | waiting for start; result and flags held
// RUN   | one nibble per cycle, idx selects the nibble
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nibble_serial_adder_if.slave  bus
);

  localparam int N    = num_nibbles(WIDTH);
  localparam int IDXW = idx_width(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_next;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nib_a = opa_q[int'(idx_q) * NIB_W +: NIB_W];
  assign nib_b = opb_q[int'(idx_q) * NIB_W +: NIB_W];

  carry_look_ahead_adder_cin_cout_4 u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Result as it will look after this edge; used so the zero flag covers
  // the nibble being written in the final cycle.
  always_comb begin
    r_next = r_q;
    r_next[int'(idx_q) * NIB_W +: NIB_W] = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q   <= '0;
      opb_q   <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        opa_q   <= bus.A;
        opb_q   <= bus.sub ? ~bus.B : bus.B;
        carry_q <= bus.sub;
        idx_q   <= '0;
        r_q     <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
        zero_q  <= 1'b0;
      end else if (state_q == RUN) begin
        r_q     <= r_next;
        carry_q <= nib_cout;
        idx_q   <= idx_q + 1'b1;
        if (last) begin
          cout_q <= nib_cout;
          // Carry into the MSB is a ^ b ^ sum at that bit.
          ovf_q  <= opa_q[WIDTH-1] ^ opb_q[WIDTH-1] ^ nib_sum[NIB_W-1] ^ nib_cout;
          zero_q <= (r_next == '0);
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.R        = r_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] r;
    logic        cout;
    logic        ov;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) b16 ();
  nibble_serial_adder_if #(.WIDTH(4))  b4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(b4.slave));

  exp_t sb16[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, flags from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    logic [16:0] mask;
    logic [16:0] sum;
    logic [15:0] am;
    logic [15:0] bb;
    logic [15:0] r;
    exp_t        e;
    mask   = (17'd1 << w) - 17'd1;
    am     = a & mask[15:0];
    bb     = s ? (~b & mask[15:0]) : (b & mask[15:0]);
    sum    = {1'b0, am} + {1'b0, bb} + {16'd0, s};
    r      = sum[15:0] & mask[15:0];
    e.r    = r;
    e.cout = sum[w];
    e.ov   = (am[w-1] == bb[w-1]) && (r[w-1] != am[w-1]);
    e.zero = (r == 16'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (b16.done === 1'b1) begin
      if (sb16.size() == 0) begin
        check("unexpected_done", {15'd0, b16.done}, 16'd0);
      end else begin
        e = sb16.pop_front();
        check("R",        b16.R, e.r);
        check("cout",     {15'd0, b16.cout}, {15'd0, e.cout});
        check("overflow", {15'd0, b16.overflow}, {15'd0, e.ov});
        check("zero",     {15'd0, b16.zero}, {15'd0, e.zero});
      end
    end
  end

  // Called at a negedge; the following posedge accepts the request.
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input bit push);
    b16.A     = a;
    b16.B     = b;
    b16.sub   = s;
    b16.start = 1'b1;
    if (push) sb16.push_back(model(16, a, b, s));
    @(negedge clk);
    b16.start = 1'b0;
    b16.A     = 16'($urandom);
    b16.B     = 16'($urandom);
    b16.sub   = 1'($urandom);
  endtask

  // Entered at the negedge after the accept edge; returns in the done cycle.
  task automatic expect_run16();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("busy_run",   {15'd0, b16.busy}, 16'd1);
      check("done_run",   {15'd0, b16.done}, 16'd0);
      check("flags_run",  {13'd0, b16.cout, b16.overflow, b16.zero}, 16'd0);
    end
    @(negedge clk);
    check("done_pulse", {15'd0, b16.done}, 16'd1);
    check("busy_done",  {15'd0, b16.busy}, 16'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
    exp_t e;
    e = model(4, {12'd0, a}, {12'd0, b}, s);
    b4.A = a; b4.B = b; b4.sub = s; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    check("w4_busy",  {15'd0, b4.busy}, 16'd1);
    check("w4_done0", {15'd0, b4.done}, 16'd0);
    @(negedge clk);
    check("w4_done",  {15'd0, b4.done}, 16'd1);
    check("w4_idle",  {15'd0, b4.busy}, 16'd0);
    check("w4_R",     {12'd0, b4.R}, e.r);
    check("w4_flags", {13'd0, b4.cout, b4.overflow, b4.zero}, {13'd0, e.cout, e.ov, e.zero});
    @(negedge clk);
    check("w4_done_fall", {15'd0, b4.done}, 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    b16.start = 1'b0; b16.sub = 1'b0; b16.A = '0; b16.B = '0;
    b4.start  = 1'b0; b4.sub  = 1'b0; b4.A  = '0; b4.B  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {15'd0, b16.busy}, 16'd0);
    check("rst_done",  {15'd0, b16.done}, 16'd0);
    check("rst_R",     b16.R, 16'd0);
    check("rst_flags", {13'd0, b16.cout, b16.overflow, b16.zero}, 16'd0);
    check("rst_w4",    {10'd0, b4.busy, b4.done, b4.R}, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    issue16(16'h1234, 16'h4321, 1'b0, 1'b1); expect_run16();
    @(negedge clk);
    check("done_fall", {15'd0, b16.done}, 16'd0);
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b1); expect_run16();
    @(negedge clk);
    issue16(16'h0005, 16'h0007, 1'b1, 1'b1); expect_run16();
    @(negedge clk);
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b1); expect_run16();
    @(negedge clk);
    issue16(16'h8000, 16'h0001, 1'b1, 1'b1); expect_run16();
    @(negedge clk);

    // Start while busy is ignored.
    issue16(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    check("busy_t1", {15'd0, b16.busy}, 16'd1);
    @(negedge clk);
    b16.start = 1'b1; b16.A = 16'hAAAA; b16.B = 16'h5555; b16.sub = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    check("busy_t3", {15'd0, b16.busy}, 16'd1);
    @(negedge clk);
    check("busy_t4", {15'd0, b16.busy}, 16'd1);
    @(negedge clk);
    check("done_ign", {15'd0, b16.done}, 16'd1);

    // Start in the done cycle is accepted; back-to-back chain.
    issue16(16'h8000, 16'h8000, 1'b0, 1'b1); expect_run16();
    for (int i = 0; i < 4; i++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      expect_run16();
    end
    @(negedge clk);

    // Reset at t2 aborts the operation; no done may follow.
    issue16(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  {15'd0, b16.busy}, 16'd0);
    check("abort_done",  {15'd0, b16.done}, 16'd0);
    check("abort_R",     b16.R, 16'd0);
    check("abort_flags", {13'd0, b16.cout, b16.overflow, b16.zero}, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", {15'd0, b16.done}, 16'd0);
    end

    issue16(16'hC001, 16'h3FFF, 1'b0, 1'b1); expect_run16();
    @(negedge clk);

    run4(4'h9, 4'h8, 1'b0);
    run4(4'h3, 4'h5, 1'b1);
    run4(4'h8, 4'h1, 1'b1);
    run4(4'h7, 4'h9, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", 16'(sb16.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
